// File: rtl/enhanced_router_pkg.sv
// enhanced_router_pkg: port indices, grant/direction encodings, flit type and routing helpers shared by the router.
package enhanced_router_pkg;
  localparam int NPORTS = 5;
  localparam int FLIT_DWIDTH = 16;
  localparam logic [2:0] PORT_GPU = 3'd0;
  localparam logic [2:0] PORT_S1 = 3'd1;
  localparam logic [2:0] PORT_S2 = 3'd2;
  localparam logic [2:0] PORT_S3 = 3'd3;
  localparam logic [2:0] PORT_S4 = 3'd4;
  localparam logic [2:0] GRANT_NONE = 3'd7;
  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_LOOP = 2'b11
  } dir_t;
  typedef struct packed {
    logic [5:0] dest;
    logic [FLIT_DWIDTH-1:0] data;
  } flit_t;
  // Spine selection uses the low two group bits; 00 wraps to spine4.
  function automatic logic [2:0] route_target(input logic [3:0] group, input logic [3:0] local_group);
    return group == local_group ? PORT_GPU : group[1:0] == 2'b00 ? PORT_S4 : {1'b0, group[1:0]};
  endfunction
  function automatic logic [2:0] rr_index(input logic [2:0] base, input int k);
    return 3'((int'(base) + 1 + k) % NPORTS);
  endfunction
endpackage

// File: rtl/router_fifo.sv
// router_fifo: synchronous FIFO; pushes when full and pops when empty are ignored.
module router_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign full = cnt[AW];
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  end
endmodule

// File: rtl/enhanced_router.sv
// enhanced_router: leaf NoC router joining one GPU port and four spine uplinks through a one-flit-per-cycle crossbar.
// Define ROUTER_DROP_COUNT_EN to add the saturating drop_count output.
module enhanced_router
  import enhanced_router_pkg::*;
#(
  parameter int ROUTER_ID = 1,
  parameter int DWIDTH = FLIT_DWIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter logic [3:0] GROUP_ID = 4'b1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arb_enable,
  input  logic [DWIDTH-1:0] gpu_in_data,
  input  logic              gpu_in_valid,
  input  logic [5:0]        gpu_dest_addr,
  output logic [DWIDTH-1:0] gpu_out_data,
  output logic              gpu_out_valid,
  input  logic [DWIDTH-1:0] spine11_in_data,
  input  logic              spine11_in_valid,
  input  logic [5:0]        spine11_dest_addr,
  output logic [DWIDTH-1:0] spine11_out_data,
  output logic              spine11_out_valid,
  input  logic [DWIDTH-1:0] spine21_in_data,
  input  logic              spine21_in_valid,
  input  logic [5:0]        spine21_dest_addr,
  output logic [DWIDTH-1:0] spine21_out_data,
  output logic              spine21_out_valid,
  input  logic [DWIDTH-1:0] spine31_in_data,
  input  logic              spine31_in_valid,
  input  logic [5:0]        spine31_dest_addr,
  output logic [DWIDTH-1:0] spine31_out_data,
  output logic              spine31_out_valid,
  input  logic [DWIDTH-1:0] spine41_in_data,
  input  logic              spine41_in_valid,
  input  logic [5:0]        spine41_dest_addr,
  output logic [DWIDTH-1:0] spine41_out_data,
  output logic              spine41_out_valid,
  output logic [3:0]        spine_fifo_in_full,
  output logic [3:0]        spine_fifo_in_empty,
  output logic [3:0]        spine_fifo_out_full,
  output logic [3:0]        spine_fifo_out_empty,
  output logic              gpu_fifo_in_full,
  output logic              gpu_fifo_in_empty,
  output logic              gpu_fifo_out_full,
  output logic              gpu_fifo_out_empty,
  output logic              crossbar_busy,
  output logic [2:0]        current_grant,
`ifdef ROUTER_DROP_COUNT_EN
  output logic [15:0]       drop_count,
`endif
  output logic [1:0]        routing_direction
);
  localparam int unused_router_id = ROUTER_ID;
  flit_t in_flit [NPORTS];
  flit_t head [NPORTS];
  logic [NPORTS-1:0] in_valid, in_full, in_empty, in_pop, out_push, out_full, out_empty, req, drop;
  logic [DWIDTH-1:0] out_head [NPORTS];
  logic [DWIDTH-1:0] out_q [NPORTS];
  logic out_v [NPORTS];
  logic [2:0] tgt [NPORTS];
  logic [2:0] gnt, rr_ptr, grant_q;
  logic gnt_valid, busy_q;
  dir_t dir_q;
  logic [9:0] unused_dest_lsbs;
  assign in_valid = {spine41_in_valid, spine31_in_valid, spine21_in_valid, spine11_in_valid, gpu_in_valid};
  assign in_flit[PORT_GPU] = '{dest: gpu_dest_addr, data: gpu_in_data};
  assign in_flit[PORT_S1] = '{dest: spine11_dest_addr, data: spine11_in_data};
  assign in_flit[PORT_S2] = '{dest: spine21_dest_addr, data: spine21_in_data};
  assign in_flit[PORT_S3] = '{dest: spine31_dest_addr, data: spine31_in_data};
  assign in_flit[PORT_S4] = '{dest: spine41_dest_addr, data: spine41_in_data};
  assign unused_dest_lsbs = {head[4].dest[1:0], head[3].dest[1:0], head[2].dest[1:0], head[1].dest[1:0], head[0].dest[1:0]};
  genvar i;
  for (i = 0; i < NPORTS; i++) begin : g_port
    router_fifo #(.W($bits(flit_t)), .DEPTH(FIFO_DEPTH)) u_in (
      .clk, .reset, .push(in_valid[i]), .pop(in_pop[i]), .din(in_flit[i]),
      .dout(head[i]), .full(in_full[i]), .empty(in_empty[i])
    );
    router_fifo #(.W(DWIDTH), .DEPTH(FIFO_DEPTH)) u_out (
      .clk, .reset, .push(out_push[i]), .pop(!out_empty[i]), .din(head[gnt].data),
      .dout(out_head[i]), .full(out_full[i]), .empty(out_empty[i])
    );
    assign tgt[i] = route_target(head[i].dest[5:2], GROUP_ID);
    // Leaf routers never forward spine-to-spine; such heads are discarded in place.
    assign drop[i] = (i != PORT_GPU) && !in_empty[i] && tgt[i] != PORT_GPU;
    assign req[i] = !in_empty[i] && !drop[i] && !out_full[tgt[i]];
    assign in_pop[i] = (gnt_valid && gnt == 3'(i)) || drop[i];
    assign out_push[i] = gnt_valid && tgt[gnt] == 3'(i);
    always_ff @(posedge clk) begin
      if (!reset) begin
        out_v[i] <= 1'b0;
        out_q[i] <= '0;
      end else begin
        out_v[i] <= !out_empty[i];
        if (!out_empty[i]) out_q[i] <= out_head[i];
      end
    end
  end
  always_comb begin
    gnt_valid = 1'b0;
    gnt = PORT_GPU;
    for (int k = 0; k < NPORTS; k++)
      if (!gnt_valid && req[arb_enable ? rr_index(rr_ptr, k) : 3'(k)]) begin
        gnt_valid = 1'b1;
        gnt = arb_enable ? rr_index(rr_ptr, k) : 3'(k);
      end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= 1'b0;
      grant_q <= GRANT_NONE;
      dir_q <= DIR_IDLE;
      rr_ptr <= PORT_GPU;
    end else begin
      busy_q <= gnt_valid;
      grant_q <= gnt_valid ? gnt : GRANT_NONE;
      dir_q <= !gnt_valid ? DIR_IDLE : gnt != PORT_GPU ? DIR_DOWN : tgt[PORT_GPU] == PORT_GPU ? DIR_LOOP : DIR_UP;
      if (gnt_valid) rr_ptr <= gnt;
    end
  end
`ifdef ROUTER_DROP_COUNT_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + 17'($countones({in_valid & in_full, drop}));
  always_ff @(posedge clk)
    drop_count <= !reset ? '0 : drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`endif
  assign gpu_out_data = out_q[PORT_GPU];
  assign gpu_out_valid = out_v[PORT_GPU];
  assign spine11_out_data = out_q[PORT_S1];
  assign spine11_out_valid = out_v[PORT_S1];
  assign spine21_out_data = out_q[PORT_S2];
  assign spine21_out_valid = out_v[PORT_S2];
  assign spine31_out_data = out_q[PORT_S3];
  assign spine31_out_valid = out_v[PORT_S3];
  assign spine41_out_data = out_q[PORT_S4];
  assign spine41_out_valid = out_v[PORT_S4];
  assign spine_fifo_in_full = in_full[4:1];
  assign spine_fifo_in_empty = in_empty[4:1];
  assign spine_fifo_out_full = out_full[4:1];
  assign spine_fifo_out_empty = out_empty[4:1];
  assign gpu_fifo_in_full = in_full[0];
  assign gpu_fifo_in_empty = in_empty[0];
  assign gpu_fifo_out_full = out_full[0];
  assign gpu_fifo_out_empty = out_empty[0];
  assign crossbar_busy = busy_q;
  assign current_grant = grant_q;
  assign routing_direction = dir_q;
endmodule

// File: tb/tb_enhanced_router.sv
// tb_enhanced_router: directed and random traffic against a queue-based router model.
module tb_enhanced_router;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic arb = 1'b0;
  logic in_v [5];
  logic [15:0] in_d [5];
  logic [5:0] in_a [5];
  logic [15:0] o_d [5];
  logic o_v [5];
  logic [3:0] sif, sie, sof, soe;
  logic gif, gie, gof, goe, busy;
  logic [2:0] grant;
  logic [1:0] dir;
  logic [15:0] dc;
  int vectors = 0;
  int miscompares = 0;
  logic [21:0] inq [5][$];
  logic [15:0] outq [5][$];
  logic m_v [5];
  logic [15:0] m_d [5];
  logic m_busy;
  logic [2:0] m_grant;
  logic [1:0] m_dir;
  int rr = 0;
  int m_drop = 0;

  always #5 clk = ~clk;

  enhanced_router dut (
    .clk(clk), .reset(reset), .arb_enable(arb),
    .gpu_in_data(in_d[0]), .gpu_in_valid(in_v[0]), .gpu_dest_addr(in_a[0]),
    .gpu_out_data(o_d[0]), .gpu_out_valid(o_v[0]),
    .spine11_in_data(in_d[1]), .spine11_in_valid(in_v[1]), .spine11_dest_addr(in_a[1]),
    .spine11_out_data(o_d[1]), .spine11_out_valid(o_v[1]),
    .spine21_in_data(in_d[2]), .spine21_in_valid(in_v[2]), .spine21_dest_addr(in_a[2]),
    .spine21_out_data(o_d[2]), .spine21_out_valid(o_v[2]),
    .spine31_in_data(in_d[3]), .spine31_in_valid(in_v[3]), .spine31_dest_addr(in_a[3]),
    .spine31_out_data(o_d[3]), .spine31_out_valid(o_v[3]),
    .spine41_in_data(in_d[4]), .spine41_in_valid(in_v[4]), .spine41_dest_addr(in_a[4]),
    .spine41_out_data(o_d[4]), .spine41_out_valid(o_v[4]),
    .spine_fifo_in_full(sif), .spine_fifo_in_empty(sie),
    .spine_fifo_out_full(sof), .spine_fifo_out_empty(soe),
    .gpu_fifo_in_full(gif), .gpu_fifo_in_empty(gie),
    .gpu_fifo_out_full(gof), .gpu_fifo_out_empty(goe),
    .crossbar_busy(busy), .current_grant(grant),
`ifdef ROUTER_DROP_COUNT_EN
    .drop_count(dc),
`endif
    .routing_direction(dir)
  );
`ifndef ROUTER_DROP_COUNT_EN
  assign dc = 16'd0;
`endif

  // Destination port: local group goes to the GPU, otherwise spine n for dest[3:2]=n, with 0 meaning spine4.
  function automatic int dest_port(input logic [5:0] a);
    if (a[5:2] == 4'b1000) return 0;
    return a[3:2] == 2'd0 ? 4 : int'(a[3:2]);
  endfunction

  function automatic logic [126:0] obs();
    return {o_v[0], o_d[0], o_v[1], o_d[1], o_v[2], o_d[2], o_v[3], o_d[3], o_v[4], o_d[4],
            sif, gif, sie, gie, sof, gof, soe, goe, busy, grant, dir, dc};
  endfunction

  function automatic logic [126:0] expv();
    logic [3:0] a, b, c, d;
    logic [15:0] e;
    for (int i = 1; i < 5; i++) begin
      a[i-1] = inq[i].size() == DEPTH;
      b[i-1] = inq[i].size() == 0;
      c[i-1] = outq[i].size() == DEPTH;
      d[i-1] = outq[i].size() == 0;
    end
`ifdef ROUTER_DROP_COUNT_EN
    e = 16'(m_drop);
`else
    e = 16'd0;
`endif
    return {m_v[0], m_d[0], m_v[1], m_d[1], m_v[2], m_d[2], m_v[3], m_d[3], m_v[4], m_d[4],
            a, inq[0].size() == DEPTH, b, inq[0].size() == 0,
            c, outq[0].size() == DEPTH, d, outq[0].size() == 0,
            m_busy, m_grant, m_dir, e};
  endfunction

  // One clock edge of the reference: every decision is taken from the state before the edge.
  task automatic model_step();
    int tgt [5];
    bit req [5], drp [5], inf [5];
    int g, nd, idx;
    logic [21:0] f;
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        inq[i].delete();
        outq[i].delete();
        m_v[i] = 1'b0;
        m_d[i] = 16'd0;
      end
      m_busy = 1'b0;
      m_grant = 3'd7;
      m_dir = 2'b00;
      rr = 0;
      m_drop = 0;
      return;
    end
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      inf[i] = inq[i].size() == DEPTH;
      tgt[i] = 0;
      drp[i] = 0;
      req[i] = 0;
      if (inq[i].size() > 0) begin
        tgt[i] = dest_port(inq[i][0][21:16]);
        drp[i] = i > 0 && tgt[i] != 0;
        req[i] = !drp[i] && outq[tgt[i]].size() < DEPTH;
      end
    end
    g = -1;
    for (int k = 0; k < 5; k++) begin
      idx = arb ? (rr + 1 + k) % 5 : k;
      if (g < 0 && req[idx]) g = idx;
    end
    m_busy = g >= 0;
    m_grant = g >= 0 ? 3'(g) : 3'd7;
    m_dir = g < 0 ? 2'b00 : g > 0 ? 2'b10 : tgt[0] == 0 ? 2'b11 : 2'b01;
    for (int t = 0; t < 5; t++) begin
      m_v[t] = outq[t].size() > 0;
      if (m_v[t]) m_d[t] = outq[t].pop_front();
    end
    if (g >= 0) begin
      rr = g;
      f = inq[g].pop_front();
      outq[tgt[g]].push_back(f[15:0]);
    end
    for (int i = 0; i < 5; i++)
      if (drp[i]) begin
        void'(inq[i].pop_front());
        nd++;
      end
    for (int i = 0; i < 5; i++)
      if (in_v[i]) begin
        if (inf[i]) nd++;
        else inq[i].push_back({in_a[i], in_d[i]});
      end
    m_drop = m_drop + nd > 65535 ? 65535 : m_drop + nd;
  endtask

  task automatic idle();
    for (int i = 0; i < 5; i++) in_v[i] = 1'b0;
  endtask

  task automatic send(input int p, input logic [5:0] a, input logic [15:0] d);
    in_v[p] = 1'b1;
    in_a[p] = a;
    in_d[p] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    vectors++;
    if (obs() !== expv()) begin
      miscompares++;
      $display("FAIL reset_state dut=%h model=%h", obs(), expv());
    end
    vectors++;
    if ({gie, sie, goe, soe, gif, sif, gof, sof, busy, grant, dir} !== {1'b1, 4'hF, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd7, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_flags got=%b want=%b", {gie, sie, goe, soe, gif, sif, gof, sof, busy, grant, dir},
               {1'b1, 4'hF, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd7, 2'b00});
    end
  endtask

  task automatic test_fixed_priority();
    logic [5:0] dst [4];
    logic [15:0] d;
    dst = '{6'b000100, 6'b001000, 6'b001100, 6'b010000};
    arb = 1'b0;
    for (int j = 0; j < 4; j++) begin
      d = 16'(16'h00A1 + j);
      send(0, dst[j], d);
      for (int c = 0; c < 3; c++) begin
        tick();
        idle();
        vectors++;
        if (obs() !== expv()) begin
          miscompares++;
          $display("FAIL fixed_prio j%0d c%0d dut=%h model=%h", j, c, obs(), expv());
        end
      end
      vectors++;
      if ({o_v[j+1], o_d[j+1]} !== {1'b1, d}) begin
        miscompares++;
        $display("FAIL fixed_prio_out spine%0d got=%b/%h want=1/%h", j + 1, o_v[j+1], o_d[j+1], d);
      end
    end
  endtask

  task automatic test_spine_to_gpu();
    arb = 1'b0;
    for (int p = 1; p < 5; p++) send(p, {4'b1000, 2'(p - 1)}, 16'(16'h00B0 + p));
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL spine_gpu k%0d dut=%h model=%h", k, obs(), expv());
      end
      if (k < 4) begin
        vectors++;
        if ({grant, dir} !== {3'(k + 1), 2'b10}) begin
          miscompares++;
          $display("FAIL spine_gpu_grant k%0d got=%0d/%b want=%0d/10", k, grant, dir, k + 1);
        end
      end
      if (k > 0) begin
        vectors++;
        if ({o_v[0], o_d[0]} !== {1'b1, 16'(16'h00B0 + k)}) begin
          miscompares++;
          $display("FAIL spine_gpu_data k%0d got=%b/%h want=1/%h", k, o_v[0], o_d[0], 16'h00B0 + k);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    arb = 1'b1;
    send(0, 6'b000100, 16'h00C1);
    send(1, 6'b100000, 16'h00C2);
    send(2, 6'b100001, 16'h00C3);
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL rr k%0d dut=%h model=%h", k, obs(), expv());
      end
      if (k < 3) begin
        vectors++;
        if (grant !== 3'(k)) begin
          miscompares++;
          $display("FAIL rr_grant k%0d got=%0d want=%0d", k, grant, k);
        end
      end
      if (k == 1) begin
        vectors++;
        if ({o_v[1], o_d[1]} !== {1'b1, 16'h00C1}) begin
          miscompares++;
          $display("FAIL rr_spine1 got=%b/%h want=1/00c1", o_v[1], o_d[1]);
        end
      end
      if (k == 2 || k == 3) begin
        vectors++;
        if ({o_v[0], o_d[0]} !== {1'b1, k == 2 ? 16'h00C2 : 16'h00C3}) begin
          miscompares++;
          $display("FAIL rr_gpu k%0d got=%b/%h want=1/%h", k, o_v[0], o_d[0], k == 2 ? 16'h00C2 : 16'h00C3);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic saw_full;
    saw_full = 1'b0;
    arb = 1'b1;
    for (int c = 0; c < 6; c++) begin
      send(0, 6'b000100, 16'(16'h00D0 + c));
      for (int p = 1; p < 5; p++) send(p, {4'b1000, 2'(p - 1)}, 16'(16'h0E00 + 16 * p + c));
      tick();
      saw_full |= gif;
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL overflow c%0d dut=%h model=%h", c, obs(), expv());
      end
    end
    idle();
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL overflow_drain c%0d dut=%h model=%h", c, obs(), expv());
      end
    end
    vectors++;
    if (saw_full !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_full got=%b want=1", saw_full);
    end
`ifdef ROUTER_DROP_COUNT_EN
    vectors++;
    if (dc == 16'd0) begin
      miscompares++;
      $display("FAIL overflow_dropcount got=%0d want>0", dc);
    end
`endif
  endtask

  task automatic test_nonlocal_drop();
    arb = 1'b0;
    send(1, 6'b000100, 16'h00F1);
    tick();
    idle();
    vectors++;
    if (sie[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_queued got=%b want=0", sie[0]);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if ({sie[0], o_v[0], o_v[1], o_v[2], o_v[3], o_v[4], busy} !== 7'b1000000 || obs() !== expv()) begin
        miscompares++;
        $display("FAIL drop_nonlocal c%0d dut=%h model=%h", c, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    arb = 1'b1;
    for (int c = 0; c < 3; c++) begin
      send(0, 6'b001000, 16'(16'h1100 + c));
      send(2, 6'b100010, 16'(16'h2200 + c));
      send(3, 6'b100011, 16'(16'h3300 + c));
      tick();
    end
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++;
    if ({gie, sie, goe, soe, busy, grant, dir, dc} !== {1'b1, 4'hF, 1'b1, 4'hF, 1'b0, 3'd7, 2'b00, 16'd0} || obs() !== expv()) begin
      miscompares++;
      $display("FAIL reset_mid dut=%h model=%h", obs(), expv());
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if ({o_v[0], o_v[1], o_v[2], o_v[3], o_v[4]} !== 5'b0 || obs() !== expv()) begin
        miscompares++;
        $display("FAIL reset_mid_quiet c%0d dut=%h model=%h", c, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) arb = 1'($urandom_range(0, 1));
      for (int p = 0; p < 5; p++) begin
        in_v[p] = 1'($urandom_range(0, 1));
        in_d[p] = 16'($urandom);
        in_a[p] = (p > 0 && $urandom_range(0, 3) != 0) ? {4'b1000, 2'($urandom)} : 6'($urandom);
      end
      tick();
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL random c%0d dut=%h model=%h", c, obs(), expv());
      end
    end
    idle();
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL random_drain c%0d dut=%h model=%h", c, obs(), expv());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      in_v[i] = 1'b0;
      in_d[i] = 16'd0;
      in_a[i] = 6'd0;
    end
    test_reset();
    test_fixed_priority();
    test_spine_to_gpu();
    test_round_robin();
    test_overflow();
    test_nonlocal_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
